// File: rtl/bc_pkg.sv
// Shared types and helpers for the Bulls-and-Cows round controller.
package bc_pkg;

  // state | meaning
  // IDLE  | waiting for the first save after reset
  // PLAY  | round in progress, guesses are counted
  // WIN   | last guess scored four bulls
  // LOSE  | all allowed attempts used without a win
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } bc_state_e;

  // Largest attempt count the 4-bit try counter can hold.
  localparam int MAX_TRIES_LIM = 15;

  // Highest legal bull/cow count; larger inputs are clamped to this.
  localparam logic [2:0] RES_MAX = 3'd4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a} pattern for 0..9; blank or out-of-range gives all off.
  function automatic logic [6:0] seg_decode(input logic [3:0] val, input logic blank);
    logic [6:0] s;
    s = SEG_BLANK;
    if (!blank) begin
      case (val)
        4'd0:    s = 7'h3F;
        4'd1:    s = 7'h06;
        4'd2:    s = 7'h5B;
        4'd3:    s = 7'h4F;
        4'd4:    s = 7'h66;
        4'd5:    s = 7'h6D;
        4'd6:    s = 7'h7D;
        4'd7:    s = 7'h07;
        4'd8:    s = 7'h7F;
        4'd9:    s = 7'h6F;
        default: s = SEG_BLANK;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/bc_round_ctrl_if.sv
// Game-side signal bundle: raw buttons and score in, strobe, status and display out.
interface bc_round_ctrl_if;
  logic       save_btn;
  logic       guess_btn;
  logic [2:0] bulls;
  logic [2:0] cows;
  logic       save;
  logic [1:0] state;
  logic [3:0] tries;
  logic       win;
  logic       lose;
  logic [6:0] seg;
  logic [3:0] an;

  // Board / button side.
  modport master (
    output save_btn, guess_btn, bulls, cows,
    input  save, state, tries, win, lose, seg, an
  );

  // Round controller side.
  modport slave (
    input  save_btn, guess_btn, bulls, cows,
    output save, state, tries, win, lose, seg, an
  );
endinterface

// File: rtl/bc_btn_sync.sv
// Brings a raw asynchronous button into the clock domain and emits a
// single-cycle pulse on each press, however long the button is held.
module bc_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync_d;

  // Two-flop synchronizer followed by a delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= btn;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign pulse = sync2 & ~sync_d;

endmodule

// File: rtl/bc_round_ctrl.sv
// Round controller: debounced buttons, game FSM, try counter, last-result
// latches and the 4-digit multiplexed 7-segment scan.
//
// state | meaning
// IDLE  | no round started yet; guesses ignored
// PLAY  | counting guesses, latching each result
// WIN   | four bulls seen; result frozen until save
// LOSE  | MAX_TRIES reached without a win; frozen until save
module bc_round_ctrl
  import bc_pkg::*;
#(
  parameter int MAX_TRIES = 10,
  parameter int SCAN_DIV  = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  bc_round_ctrl_if.slave  bus
);

  localparam logic [3:0]       MAX_T    = 4'(MAX_TRIES);
  localparam int               CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic save_p;
  logic guess_p;

  bc_btn_sync u_save_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.save_btn),
    .pulse (save_p)
  );

  bc_btn_sync u_guess_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.guess_btn),
    .pulse (guess_p)
  );

  bc_state_e  state_q, state_d;
  logic [3:0] tries_q, tries_d;
  logic [2:0] lb_q, lb_d;
  logic [2:0] lc_q, lc_d;
  logic       save_q, save_d;
  logic       win_q;
  logic       lose_q;

  // Next-state and datapath decisions; save has priority over guess in every state.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    lb_d    = lb_q;
    lc_d    = lc_q;
    save_d  = 1'b0;
    if (save_p) begin
      save_d  = 1'b1;
      tries_d = 4'd0;
      lb_d    = 3'd0;
      lc_d    = 3'd0;
      state_d = ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (guess_p) begin
            lb_d    = (bus.bulls > RES_MAX) ? RES_MAX : bus.bulls;
            lc_d    = (bus.cows  > RES_MAX) ? RES_MAX : bus.cows;
            tries_d = tries_q + 4'd1;
            if (bus.bulls >= RES_MAX)  state_d = ST_WIN;
            else if (tries_d == MAX_T) state_d = ST_LOSE;
          end
        end
        default: ;
      endcase
    end
  end

  // Game state register; win/lose follow the next state so all change together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tries_q <= 4'd0;
      lb_q    <= 3'd0;
      lc_q    <= 3'd0;
      save_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      lb_q    <= lb_d;
      lc_q    <= lc_d;
      save_q  <= save_d;
      win_q   <= (state_d == ST_WIN);
      lose_q  <= (state_d == ST_LOSE);
    end
  end

  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q;
  logic [3:0]       digit;
  logic             blank;
  logic             tens;
  logic [3:0]       ones;

  // Pick the digit for the enable that will be active after this edge.
  always_comb begin
    an_d  = (cnt_q == CNT_LAST) ? {an_q[2:0], an_q[3]} : an_q;
    tens  = (tries_q >= 4'd10);
    ones  = tens ? (tries_q - 4'd10) : tries_q;
    blank = 1'b0;
    case (an_d)
      4'b1000: begin
        digit = {3'b000, tens};
        blank = ~tens;
      end
      4'b0100: digit = ones;
      4'b0010: digit = {1'b0, lb_q};
      default: digit = {1'b0, lc_q};
    endcase
  end

  // Scan counter, digit enable rotation and registered segment pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      an_q  <= 4'b0001;
      seg_q <= 7'h3F;
    end else begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      an_q  <= an_d;
      seg_q <= seg_decode(digit, blank);
    end
  end

  assign bus.save  = save_q;
  assign bus.state = state_q;
  assign bus.tries = tries_q;
  assign bus.win   = win_q;
  assign bus.lose  = lose_q;
  assign bus.seg   = seg_q;
  assign bus.an    = an_q;

endmodule

// File: tb/tb_bc_round_ctrl.sv
// Bench for bc_round_ctrl: two instances (MAX_TRIES 10 and 3) share one
// stimulus stream and are compared every cycle against a game-rule model.
module tb_bc_round_ctrl;

  localparam int MT_A  = 10;
  localparam int DIV_A = 4;
  localparam int MT_B  = 3;
  localparam int DIV_B = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sb = 1'b0;
  logic       gb = 1'b0;
  logic [2:0] bl = 3'd0;
  logic [2:0] cw = 3'd0;

  always #5 clk = ~clk;

  bc_round_ctrl_if ifa ();
  bc_round_ctrl_if ifb ();

  assign ifa.save_btn  = sb;
  assign ifa.guess_btn = gb;
  assign ifa.bulls     = bl;
  assign ifa.cows      = cw;
  assign ifb.save_btn  = sb;
  assign ifb.guess_btn = gb;
  assign ifb.bulls     = bl;
  assign ifb.cows      = cw;

  bc_round_ctrl #(.MAX_TRIES(MT_A), .SCAN_DIV(DIV_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bc_round_ctrl #(.MAX_TRIES(MT_B), .SCAN_DIV(DIV_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int errors = 0;
  int checks = 0;

  int segtab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  int mt  [2] = '{MT_A, MT_B};
  int div [2] = '{DIV_A, DIV_B};

  // Model: game state 0..3, tries, last result, save strobe, cycles since reset release.
  int m_st [2], m_tr [2], m_lb [2], m_lc [2], m_sv [2], m_n [2], m_seg [2], m_an [2];
  // Button samples taken at the previous three edges.
  bit hs1, hs2, hs3, hg1, hg2, hg3;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(bit r, bit s, bit g, int b, int c);
    bit sp, gp;
    if (!r) begin
      for (int d = 0; d < 2; d++) begin
        m_st[d] = 0; m_tr[d] = 0; m_lb[d] = 0; m_lc[d] = 0; m_sv[d] = 0;
        m_n[d] = 0; m_seg[d] = 'h3F; m_an[d] = 1;
      end
      {hs1, hs2, hs3, hg1, hg2, hg3} = '0;
      return;
    end
    // A press first sampled at edge k acts at edge k+2.
    sp = hs2 && !hs3;
    gp = hg2 && !hg3;
    hs3 = hs2; hs2 = hs1; hs1 = s;
    hg3 = hg2; hg2 = hg1; hg1 = g;
    for (int d = 0; d < 2; d++) begin
      int idx, tn;
      m_n[d]++;
      idx = (m_n[d] / div[d]) % 4;
      m_an[d] = 1 << idx;
      tn = m_tr[d] / 10;
      case (idx)
        3: m_seg[d] = (tn == 0) ? 0 : segtab[tn];
        2: m_seg[d] = segtab[m_tr[d] % 10];
        1: m_seg[d] = segtab[m_lb[d]];
        default: m_seg[d] = segtab[m_lc[d]];
      endcase
      m_sv[d] = 0;
      if (sp) begin
        m_sv[d] = 1; m_tr[d] = 0; m_lb[d] = 0; m_lc[d] = 0; m_st[d] = 1;
      end else if (gp && m_st[d] == 1) begin
        m_lb[d] = (b > 4) ? 4 : b;
        m_lc[d] = (c > 4) ? 4 : c;
        m_tr[d]++;
        if (b >= 4) m_st[d] = 2;
        else if (m_tr[d] == mt[d]) m_st[d] = 3;
      end
    end
  endtask

  task automatic check_outs(string nm, int d, logic sv, logic [1:0] st, logic [3:0] tr,
                            logic w, logic l, logic [6:0] sg, logic [3:0] a);
    chk({nm, ".save"},  sv, m_sv[d]);
    chk({nm, ".state"}, st, m_st[d]);
    chk({nm, ".tries"}, tr, m_tr[d]);
    chk({nm, ".win"},   w,  (m_st[d] == 2) ? 1 : 0);
    chk({nm, ".lose"},  l,  (m_st[d] == 3) ? 1 : 0);
    chk({nm, ".seg"},   sg, m_seg[d]);
    chk({nm, ".an"},    a,  m_an[d]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(rst_n, sb, gb, bl, cw);
    #1;
    check_outs("a", 0, ifa.save, ifa.state, ifa.tries, ifa.win, ifa.lose, ifa.seg, ifa.an);
    check_outs("b", 1, ifb.save, ifb.state, ifb.tries, ifb.win, ifb.lose, ifb.seg, ifb.an);
  endtask

  task automatic press(bit s, bit g, int hold, int gap, int b, int c);
    bl = 3'(b);
    cw = 3'(c);
    sb = s;
    gb = g;
    repeat (hold) cycle();
    sb = 1'b0;
    gb = 1'b0;
    repeat (gap) cycle();
  endtask

  initial begin
    repeat (3) cycle();
    rst_n = 1'b1;
    // Held save gives one strobe; guess in IDLE beforehand is ignored.
    press(0, 1, 3, 3, 2, 2);
    press(1, 0, 20, 4, 0, 0);
    // First guess, then let the scan run through all digits.
    press(0, 1, 3, 3, 1, 2);
    repeat (24) cycle();
    // Win on try 3 for both instances; further guesses ignored.
    press(0, 1, 2, 3, 0, 3);
    press(0, 1, 2, 3, 4, 0);
    press(0, 1, 2, 3, 1, 1);
    repeat (10) cycle();
    // New round: B loses at 3, A runs on to its 10-try limit (tens digit shown).
    press(1, 0, 2, 4, 0, 0);
    for (int i = 0; i < 10; i++) press(0, 1, 1, 3, i % 4, 7 - (i % 4));
    repeat (30) cycle();
    // Simultaneous save and guess at tries=2: save wins.
    press(1, 0, 1, 4, 0, 0);
    press(0, 1, 1, 3, 2, 1);
    press(0, 1, 1, 3, 3, 0);
    press(1, 1, 2, 4, 3, 3);
    // Mid-round reset with tries=5 on A.
    for (int i = 0; i < 5; i++) press(0, 1, 2, 2, 1, 1);
    rst_n = 1'b0;
    sb = 1'b1;
    cycle();
    rst_n = 1'b1;
    sb = 1'b0;
    repeat (4) cycle();
    // Randomized play.
    for (int i = 0; i < 260; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) cycle();
        rst_n = 1'b1;
      end else begin
        press(r < 12, r >= 9, $urandom_range(1, 5), $urandom_range(0, 4),
              ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3),
              $urandom_range(0, 5));
      end
    end
    repeat (5) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
